inst_encoder: RTL and testbench

Packs decoded RV32I instruction fields (opcode, funct3, bit30, rd, rs1, rs2, immediate) back into 32-bit instruction words. It is the inverse of the core's control-path decoder. Encoded words are queued in a small FIFO, each stamped with a sequential IMEM word address, and presented on a valid/ready port to the IMEM write path. It is used by the bootloader/test loader to build programs in instruction memory.

---
 rtl/inst_encoder_pkg.sv | 45 ++++
 rtl/inst_encoder_fifo.sv | 64 ++++++
 rtl/inst_encoder.sv | 187 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// inst_encoder shared constants: RV32I opcodes, funct3 codes
// and instruction format codes used by the encoder.
package inst_encoder_pkg;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_X,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    unique case (1'b1)
      (op == OP_LUI),
      (op == OP_AUIPC):     f = FMT_U;
      (op == OP_JAL):       f = FMT_J;
      (op == OP_JALR),
      (op == OP_LOAD),
      (op == OP_ARI_ITYPE): f = FMT_I;
      (op == OP_STORE):     f = FMT_S;
      (op == OP_BRANCH):    f = FMT_B;
      (op == OP_ARI_RTYPE): f = FMT_R;
      default:              f = FMT_X;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// sync_fifo: small synchronous queue with flush.
// Head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // Next pointers and storage; flush wins over push/pop
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_d = rd_q + 1'b1;
      end
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into words queued
// for IMEM writes. Optional ENC_IMM_CHECK_EN range checks.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          ADDR_W     = 14,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_funct3,
  input  logic              req_bit30,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_inst,
  output logic              err_illegal,
  output logic              err_range,
  output logic [15:0]       enc_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  fmt_e              fmt;
  logic              shift;
  logic              legal;
  logic              imm_bad;
  logic [31:0]       inst;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ill_q, ill_d;

  assign req_ready   = !full && !start;
  assign accept      = req_valid && req_ready;
  assign push        = accept && legal && !imm_bad;
  assign pop         = out_valid && out_ready;
  assign out_valid   = !empty;
  assign err_illegal = ill_q;
  assign enc_count   = cnt_q;

  // Combinational encode of the request fields
  always_comb begin
    fmt   = fmt_of(req_opcode);
    legal = (fmt != FMT_X);
    shift = (req_opcode == OP_ARI_ITYPE) &&
            ((req_funct3 == F3_SLL) ||
             (req_funct3 == F3_SRL_SRA));
    inst  = '0;
    unique case (fmt)
      FMT_R: inst = {1'b0, req_bit30, 5'b0, req_rs2,
                     req_rs1, req_funct3, req_rd,
                     req_opcode};
      FMT_I: begin
        if (shift) begin
          inst = {1'b0, req_bit30, 5'b0, req_imm[4:0],
                  req_rs1, req_funct3, req_rd,
                  req_opcode};
        end else begin
          inst = {req_imm[11:0], req_rs1, req_funct3,
                  req_rd, req_opcode};
        end
      end
      FMT_S: inst = {req_imm[11:5], req_rs2, req_rs1,
                     req_funct3, req_imm[4:0],
                     req_opcode};
      FMT_B: inst = {req_imm[12], req_imm[10:5],
                     req_rs2, req_rs1, req_funct3,
                     req_imm[4:1], req_imm[11],
                     req_opcode};
      FMT_U: inst = {req_imm[31:12], req_rd, req_opcode};
      FMT_J: inst = {req_imm[20], req_imm[10:1],
                     req_imm[11], req_imm[19:12],
                     req_rd, req_opcode};
      FMT_X: inst = '0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  logic rng_q, rng_d;

  assign err_range = rng_q;

  // Immediate must fit the field width of its format
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I: begin
        if (shift) begin
          imm_bad = (req_imm[31:5] != '0);
        end else begin
          imm_bad = (req_imm[31:11] != {21{req_imm[11]}});
        end
      end
      FMT_S: imm_bad = (req_imm[31:11] != {21{req_imm[11]}});
      FMT_B: imm_bad = (req_imm[31:12] != {20{req_imm[12]}}) ||
                       req_imm[0];
      FMT_J: imm_bad = (req_imm[31:20] != {12{req_imm[20]}}) ||
                       req_imm[0];
      FMT_U: imm_bad = (req_imm[11:0] != '0);
      default: imm_bad = 1'b0;
    endcase
    rng_d = rng_q;
    if (start) begin
      rng_d = 1'b0;
    end else if (accept && legal && imm_bad) begin
      rng_d = 1'b1;
    end
  end

  // Sticky range error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_q <= 1'b0;
    end else begin
      rng_q <= rng_d;
    end
  end
`else
  assign imm_bad   = 1'b0;
  assign err_range = 1'b0;
`endif

  // Address counter, word count and illegal-opcode flag
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    ill_d  = ill_q;
    if (start) begin
      addr_d = BASE;
      cnt_d  = '0;
      ill_d  = 1'b0;
    end else begin
      if (push) begin
        addr_d = addr_q + 1'b1;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      if (accept && !legal) begin
        ill_d = 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE;
      cnt_q  <= '0;
      ill_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      ill_q  <= ill_d;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start),
    .push  (push),
    .din   ({addr_q, inst}),
    .pop   (pop),
    .dout  ({out_addr, out_inst}),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed + random checks of inst_encoder
// against a queue-based reference model.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic        req_bit30;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_addr;
  logic [31:0] out_inst;
  logic        err_illegal;
  logic        err_range;
  logic [15:0] enc_count;

  inst_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_funct3  (req_funct3),
    .req_bit30   (req_bit30),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_inst    (out_inst),
    .err_illegal (err_illegal),
    .err_range   (err_range),
    .enc_count   (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [31:0] i;
  } ent_t;

  ent_t        q[$];
  logic [13:0] m_addr;
  int          m_cnt;
  bit          m_ill;
  bit          m_rng;
  int          errors;
  int          checks;

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67,
                          7'h63, 7'h03, 7'h23, 7'h13,
                          7'h33};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_shift(input logic [6:0] op,
                                  input logic [2:0] f3);
    return op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5);
  endfunction

  function automatic bit ref_legal(input logic [6:0] op);
    foreach (ops[k]) if (ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Field placement straight from the RV32I format tables
  function automatic logic [31:0] ref_enc(
      input logic [6:0] op, input logic [2:0] f3,
      input logic b30, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] rdp, rs1p, rs2p, f3p;
    rdp  = 32'(rd) << 7;
    f3p  = 32'(f3) << 12;
    rs1p = 32'(rs1) << 15;
    rs2p = 32'(rs2) << 20;
    w = 32'(op);
    case (op)
      7'h37, 7'h17: w |= (imm & 32'hFFFFF000) | rdp;
      7'h6F: w |= (((imm >> 20) & 1) << 31)
                | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 1) << 20)
                | (((imm >> 12) & 32'hFF) << 12) | rdp;
      7'h67, 7'h03, 7'h13: begin
        if (is_shift(op, f3))
          w |= (32'(b30) << 30) | ((imm & 31) << 20)
             | rs1p | f3p | rdp;
        else
          w |= ((imm & 32'hFFF) << 20)
             | rs1p | f3p | rdp;
      end
      7'h23: w |= (((imm >> 5) & 32'h7F) << 25) | rs2p
                | rs1p | f3p | ((imm & 31) << 7);
      7'h63: w |= (((imm >> 12) & 1) << 31)
                | (((imm >> 5) & 32'h3F) << 25) | rs2p
                | rs1p | f3p
                | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 1) << 7);
      7'h33: w |= (32'(b30) << 30) | rs2p | rs1p
                | f3p | rdp;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic bit out_of(input int s, input int lo,
                                input int hi);
    return s < lo || s > hi;
  endfunction

  function automatic bit ref_bad(input logic [6:0] op,
                                 input logic [2:0] f3,
                                 input logic [31:0] imm);
`ifdef ENC_IMM_CHECK_EN
    int s;
    s = $signed(imm);
    case (op)
      7'h37, 7'h17: return (imm % 4096) != 0;
      7'h6F: return out_of(s, -(1 << 20), (1 << 20) - 1)
                    || (imm % 2) != 0;
      7'h63: return out_of(s, -4096, 4095)
                    || (imm % 2) != 0;
      7'h67, 7'h03, 7'h23: return out_of(s, -2048, 2047);
      7'h13: begin
        if (is_shift(op, f3)) return imm > 31;
        return out_of(s, -2048, 2047);
      end
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rnd_imm(
      input logic [6:0] op, input logic [2:0] f3);
    int v;
    if ($urandom_range(0, 7) == 0) return $urandom;
    case (op)
      7'h37, 7'h17: return $urandom & 32'hFFFFF000;
      7'h6F: begin
        v = $urandom_range(0, (1 << 21) - 1) - (1 << 20);
        return v & ~1;
      end
      7'h63: begin
        v = $urandom_range(0, 8191) - 4096;
        return v & ~1;
      end
      7'h33: return $urandom;
      default: begin
        if (is_shift(op, f3)) return $urandom_range(0, 31);
        v = $urandom_range(0, 4095) - 2048;
        return v;
      end
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = '0;
    m_cnt  = 0;
    m_ill  = 1'b0;
    m_rng  = 1'b0;
  endtask

  // Compare at negedge, advance the model, then cross posedge
  task automatic step();
    bit   acc;
    ent_t e;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("req_ready", req_ready, q.size() < 4 && !start);
    chk("err_illegal", err_illegal, m_ill);
    chk("err_range", err_range, m_rng);
    chk("enc_count", enc_count, m_cnt);
    if (q.size() > 0) begin
      chk("out_addr", out_addr, q[0].a);
      chk("out_inst", out_inst, q[0].i);
    end
    acc = req_valid && q.size() < 4 && !start;
    if (start) begin
      model_reset();
    end else begin
      if (q.size() > 0 && out_ready) e = q.pop_front();
      if (acc) begin
        if (!ref_legal(req_opcode)) begin
          m_ill = 1'b1;
        end else if (ref_bad(req_opcode, req_funct3,
                             req_imm)) begin
          m_rng = 1'b1;
        end else begin
          e.a = m_addr;
          e.i = ref_enc(req_opcode, req_funct3, req_bit30,
                        req_rd, req_rs1, req_rs2, req_imm);
          q.push_back(e);
          m_addr = m_addr + 14'd1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic b30,
                       input logic [4:0] rd,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [31:0] imm);
    req_valid  = 1'b1;
    req_opcode = op;
    req_funct3 = f3;
    req_bit30  = b30;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic pulse_start();
    idle();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    idle();
    drive(7'h0, 3'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    req_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_out_addr", out_addr, 14'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_errs", {err_illegal, err_range}, 2'b00);
    chk("rst_count", enc_count, 16'd0);

    // addi x1,x0,5 then sub x3,x1,x2
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_inst", out_inst, 32'h00500093);
    chk("addi_addr", out_addr, 14'd0);
    drive(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0);
    step();
    chk("sub_inst", out_inst, 32'h402081B3);
    chk("sub_addr", out_addr, 14'd1);
    drive(7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7);
    step();
    chk("next_addr", out_addr, 14'd2);
    pulse_start();

    // Fill with the sink stalled, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0,
            32'(i * 3));
      step();
    end
    idle();
    chk("full_ready", req_ready, 1'b0);
    chk("full_head", out_addr, 14'd0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", out_addr, 14'(i));
      step();
    end
    chk("drained", out_valid, 1'b0);

    // Illegal opcode handling and start clear
    pulse_start();
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    step();
    drive(7'h7F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    step();
    chk("ill_flag", err_illegal, 1'b1);
    chk("ill_count", enc_count, 16'd1);
    chk("ill_noout", out_valid, 1'b0);
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2);
    step();
    chk("ill_next_addr", out_addr, 14'd1);
    pulse_start();
    chk("start_ill", err_illegal, 1'b0);
    chk("start_cnt", enc_count, 16'd0);
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3);
    step();
    chk("start_addr", out_addr, 14'd0);

    // Branch encoding and odd-offset handling
    drive(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2,
          32'hFFFFFFF8);
    step();
    chk("beq_inst", out_inst, 32'hFE208CE3);
    idle();
    step();
    drive(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
    step();
`ifdef ENC_IMM_CHECK_EN
    chk("beq7_range", err_range, 1'b1);
    chk("beq7_drop", out_valid, 1'b0);
`else
    chk("beq7_range", err_range, 1'b0);
    chk("beq7_inst", out_inst, 32'h00208363);
`endif
    idle();
    step();

    // Asynchronous reset with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(7'h37, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0,
            32'h12345000);
      step();
    end
    idle();
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    chk("post_rst_addr", out_addr, 14'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      start     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0)
        op = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h00;
      else
        op = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      drive(op, f3, 1'($urandom_range(0, 1)),
            5'($urandom), 5'($urandom), 5'($urandom),
            rnd_imm(op, f3));
      req_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    start = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
